// File: rtl/pet2001_prg_loader.sv
// pet2001_prg_loader
//   Streams a .PRG file from the host download interface into the PET's 16K
//   main RAM through the DMA write port, then patches the BASIC end-of-program
//   pointers (VARTAB/ARYTAB/STREND) so the loaded program can RUN directly.
//
//   A .PRG file is a little-endian 16-bit load address followed by payload.
//   Payload landing at or above RAM_TOP is dropped and flagged in err.
//
// Ports
//   clk            system clock (shared with the PET hardware block)
//   reset_n        asynchronous active-low reset
//   ioctl_download high for the duration of a file transfer
//   ioctl_wr       one-cycle strobe, ioctl_dout valid
//   ioctl_dout     file byte
//   ioctl_wait     host must hold further strobes (pointer phase)
//   dma_addr       RAM write address
//   dma_din        RAM write data
//   dma_we         RAM write strobe, one-cycle pulse
//   busy           download or pointer phase in progress
//   done           sticky, last load completed
//   err            sticky, last load truncated or malformed
module pet2001_prg_loader #(
   parameter logic [13:0] PTR_BASE = 14'h002A,
   parameter logic [16:0] RAM_TOP  = 17'h04000,
   parameter logic        PTR_EN   = 1'b1
) (
   input  logic        clk,
   input  logic        reset_n,
   input  logic        ioctl_download,
   input  logic        ioctl_wr,
   input  logic [7:0]  ioctl_dout,
   output logic        ioctl_wait,
   output logic [13:0] dma_addr,
   output logic [7:0]  dma_din,
   output logic        dma_we,
   output logic        busy,
   output logic        done,
   output logic        err
);

   typedef enum logic [2:0] {
      S_IDLE,
      S_HDR_LO,
      S_HDR_HI,
      S_DATA,
      S_PTR,
      S_FIN
   } state_t;

   state_t      r_state;
   logic        r_rst_meta;
   logic        r_rst_sync;
   logic        r_dl_q;
   logic        r_restart;
   logic [7:0]  r_load_lo;
   logic [16:0] r_cur;
   logic [15:0] r_end;
   logic [2:0]  r_ptr_idx;
   logic        r_wait;
   logic [13:0] r_dma_addr;
   logic [7:0]  r_dma_din;
   logic        r_dma_we;
   logic        r_busy;
   logic        r_done;
   logic        r_err;

   logic        w_rst_n;
   logic        w_dl_rise;
   logic [15:0] w_end;
   logic [7:0]  w_ptr_data;

   // Reset asserts immediately but releases on a clock edge, so the state
   // machine never sees a partial deassertion.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_rst_meta <= 1'b0;
         r_rst_sync <= 1'b0;
      end else begin
         r_rst_meta <= 1'b1;
         r_rst_sync <= r_rst_meta;
      end
   end

   assign w_rst_n   = r_rst_sync;
   assign w_dl_rise = ioctl_download & ~r_dl_q;

   // cur is 17 bits wide so a load near 16'hFFFF keeps counting past RAM_TOP
   // instead of wrapping back into low RAM.
   always_comb begin
      w_end = r_cur[15:0];
      if (r_cur >= RAM_TOP) w_end = RAM_TOP[15:0];
   end

   // Pointer bytes are lo/hi pairs, so even slots take the low byte.
   assign w_ptr_data = r_ptr_idx[0] ? r_end[15:8] : r_end[7:0];

   always_ff @(posedge clk or negedge w_rst_n) begin
      if (!w_rst_n) begin
         r_state    <= S_IDLE;
         r_dl_q     <= 1'b0;
         r_restart  <= 1'b0;
         r_load_lo  <= 8'h00;
         r_cur      <= 17'h00000;
         r_end      <= 16'h0000;
         r_ptr_idx  <= 3'd0;
         r_wait     <= 1'b0;
         r_dma_addr <= 14'h0000;
         r_dma_din  <= 8'h00;
         r_dma_we   <= 1'b0;
         r_busy     <= 1'b0;
         r_done     <= 1'b0;
         r_err      <= 1'b0;
      end else begin
         r_dl_q   <= ioctl_download;
         r_dma_we <= 1'b0;
         r_wait   <= 1'b0;
         case (r_state)
            S_IDLE: begin
               if (w_dl_rise) begin
                  r_state <= S_HDR_LO;
                  r_done  <= 1'b0;
                  r_err   <= 1'b0;
                  r_busy  <= 1'b1;
               end
            end
            // Download ending during the header means the file is under 2 bytes.
            S_HDR_LO: begin
               if (!ioctl_download) begin
                  r_err   <= 1'b1;
                  r_state <= S_FIN;
               end else if (ioctl_wr) begin
                  r_load_lo <= ioctl_dout;
                  r_state   <= S_HDR_HI;
               end
            end
            S_HDR_HI: begin
               if (!ioctl_download) begin
                  r_err   <= 1'b1;
                  r_state <= S_FIN;
               end else if (ioctl_wr) begin
                  r_cur   <= {1'b0, ioctl_dout, r_load_lo};
                  r_state <= S_DATA;
               end
            end
            S_DATA: begin
               if (!ioctl_download) begin
                  r_end     <= w_end;
                  r_ptr_idx <= 3'd0;
                  if (PTR_EN) begin
                     r_state <= S_PTR;
                     r_wait  <= 1'b1;
                  end else begin
                     r_state <= S_FIN;
                  end
               end else if (ioctl_wr) begin
                  if (r_cur < RAM_TOP) begin
                     r_dma_we   <= 1'b1;
                     r_dma_addr <= r_cur[13:0];
                     r_dma_din  <= ioctl_dout;
                  end else begin
                     r_err <= 1'b1;
                  end
                  r_cur <= r_cur + 17'd1;
               end
            end
            // ioctl_wait stays high through the cycle that shows the last
            // pointer write; host strobes here are ignored.
            S_PTR: begin
               r_wait     <= 1'b1;
               r_dma_we   <= 1'b1;
               r_dma_addr <= PTR_BASE + {11'd0, r_ptr_idx};
               r_dma_din  <= w_ptr_data;
               r_ptr_idx  <= r_ptr_idx + 3'd1;
               if (w_dl_rise) r_restart <= 1'b1;
               if (r_ptr_idx == 3'd5) begin
                  r_restart <= 1'b0;
                  if (r_restart || w_dl_rise) begin
                     r_state <= S_HDR_LO;
                     r_done  <= 1'b0;
                     r_err   <= 1'b0;
                  end else begin
                     r_state <= S_FIN;
                  end
               end
            end
            S_FIN: begin
               r_busy  <= 1'b0;
               r_done  <= 1'b1;
               r_state <= S_IDLE;
               // A new download starting on this very cycle would otherwise be
               // missed by the IDLE edge detector.
               if (w_dl_rise) begin
                  r_state <= S_HDR_LO;
                  r_busy  <= 1'b1;
                  r_done  <= 1'b0;
                  r_err   <= 1'b0;
               end
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end

   assign ioctl_wait = r_wait;
   assign dma_addr   = r_dma_addr;
   assign dma_din    = r_dma_din;
   assign dma_we     = r_dma_we;
   assign busy       = r_busy;
   assign done       = r_done;
   assign err        = r_err;

endmodule

// File: tb/tb_pet2001_prg_loader.sv
`timescale 1ns/1ps
module tb_pet2001_prg_loader;

   logic        clk = 1'b0;
   logic        reset_n;
   logic        ioctl_download;
   logic        ioctl_wr;
   logic [7:0]  ioctl_dout;
   logic        ioctl_wait;
   logic [13:0] dma_addr;
   logic [7:0]  dma_din;
   logic        dma_we;
   logic        busy;
   logic        done;
   logic        err;

   always #5 clk = ~clk;

   pet2001_prg_loader dut (
      .clk            (clk),
      .reset_n        (reset_n),
      .ioctl_download (ioctl_download),
      .ioctl_wr       (ioctl_wr),
      .ioctl_dout     (ioctl_dout),
      .ioctl_wait     (ioctl_wait),
      .dma_addr       (dma_addr),
      .dma_din        (dma_din),
      .dma_we         (dma_we),
      .busy           (busy),
      .done           (done),
      .err            (err)
   );

   // kind: 0 = exact cycle, 1 = first pointer write, 2 = must follow previous write
   typedef struct {
      int addr;
      int data;
      int cyc;
      int kind;
   } wr_t;

   typedef logic [7:0] bq_t[$];

   wr_t  exp_q[$];
   wr_t  mon_e;
   int   n_checks = 0;
   int   n_fail   = 0;
   int   cyc      = 0;
   int   last_wr_cyc = 0;
   logic model_err;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
      n_checks++;
      if (obs !== exp_v) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, obs, exp_v, $time);
      end
   endtask

   // Scoreboard: every DMA write must match the next expected write in order.
   always @(negedge clk) begin
      if (dma_we === 1'b1) begin
         if (exp_q.size() == 0) begin
            chk_eq("extra_write_addr", {18'd0, dma_addr}, 32'hFFFF_FFFF);
         end else begin
            mon_e = exp_q.pop_front();
            chk_eq("wr_addr", {18'd0, dma_addr}, mon_e.addr);
            chk_eq("wr_data", {24'd0, dma_din}, mon_e.data);
            chk_eq("wr_busy", {31'd0, busy}, 1);
            if (mon_e.kind == 0) chk_eq("wr_latency", cyc, mon_e.cyc);
            if (mon_e.kind == 2) chk_eq("ptr_consecutive", cyc, last_wr_cyc + 1);
            if (mon_e.kind != 0) chk_eq("ptr_wait", {31'd0, ioctl_wait}, 1);
         end
         last_wr_cyc = cyc;
      end
   end

   // Drives one file and appends the writes the loader should produce.
   task automatic send_file(input bq_t f, input int gap, input bit do_start, input bit do_end);
      int la;
      int a;
      int e;
      wr_t w;
      if (do_start) begin
         @(negedge clk);
         ioctl_download = 1'b1;
         @(negedge clk);
         chk_eq("busy_start", {31'd0, busy}, 1);
         chk_eq("done_cleared", {31'd0, done}, 0);
      end
      model_err = 1'b0;
      la = 0;
      if (f.size() >= 1) la = int'(f[0]);
      if (f.size() >= 2) la = la | (int'(f[1]) << 8);
      for (int i = 0; i < f.size(); i++) begin
         ioctl_wr   = 1'b1;
         ioctl_dout = f[i];
         if (i >= 2) begin
            a = la + i - 2;
            if (a < 'h4000) begin
               w.addr = a;
               w.data = int'(f[i]);
               w.cyc  = cyc + 1;
               w.kind = 0;
               exp_q.push_back(w);
            end else begin
               model_err = 1'b1;
            end
         end
         @(negedge clk);
         ioctl_wr = 1'b0;
         repeat (gap - 1) @(negedge clk);
      end
      if (do_end) begin
         ioctl_download = 1'b0;
         if (f.size() < 2) begin
            model_err = 1'b1;
         end else begin
            e = la + f.size() - 2;
            if (e > 'h4000) e = 'h4000;
            for (int j = 0; j < 6; j++) begin
               w.addr = 'h2A + j;
               w.data = (j % 2 == 1) ? ((e >> 8) & 'hFF) : (e & 'hFF);
               w.cyc  = 0;
               w.kind = (j == 0) ? 1 : 2;
               exp_q.push_back(w);
            end
         end
      end
   endtask

   task automatic finish_file(input logic exp_err);
      int t;
      t = 0;
      while (done !== 1'b1 && t < 300) begin
         @(negedge clk);
         t++;
      end
      chk_eq("done", {31'd0, done}, 1);
      chk_eq("err", {31'd0, err}, {31'd0, exp_err});
      chk_eq("busy_end", {31'd0, busy}, 0);
      chk_eq("wait_end", {31'd0, ioctl_wait}, 0);
      repeat (2) @(negedge clk);
      chk_eq("writes_drained", exp_q.size(), 0);
      exp_q.delete();
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: got timeout, expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      bq_t f;
      bq_t g;
      int t;
      int sel;
      int n;
      logic [15:0] rla;

      reset_n        = 1'b0;
      ioctl_download = 1'b0;
      ioctl_wr       = 1'b0;
      ioctl_dout     = 8'h00;
      repeat (3) @(negedge clk);
      chk_eq("rst_we",   {31'd0, dma_we}, 0);
      chk_eq("rst_addr", {18'd0, dma_addr}, 0);
      chk_eq("rst_din",  {24'd0, dma_din}, 0);
      chk_eq("rst_wait", {31'd0, ioctl_wait}, 0);
      chk_eq("rst_busy", {31'd0, busy}, 0);
      chk_eq("rst_done", {31'd0, done}, 0);
      chk_eq("rst_err",  {31'd0, err}, 0);
      reset_n = 1'b1;
      repeat (4) @(negedge clk);

      // strobes outside a download do nothing
      ioctl_wr = 1'b1; ioctl_dout = 8'h77;
      @(negedge clk);
      ioctl_wr = 1'b0;
      repeat (2) @(negedge clk);
      chk_eq("idle_wr_busy", {31'd0, busy}, 0);

      // basic load
      f = {8'h01, 8'h04, 8'hAA, 8'hBB, 8'hCC};
      send_file(f, 2, 1, 1);
      finish_file(model_err);

      // back-to-back strobes
      f = {8'h00, 8'h10};
      for (int i = 0; i < 256; i++) f.push_back(8'($urandom));
      send_file(f, 1, 1, 1);
      finish_file(model_err);

      // overflow across RAM_TOP
      f = {8'hFE, 8'h3F, 8'h11, 8'h22, 8'h33, 8'h44};
      send_file(f, 1, 1, 1);
      finish_file(model_err);

      // load address near 16'hFFFF must not wrap into low RAM
      f = {8'hFF, 8'hFF, 8'h5A, 8'h6B, 8'h7C};
      send_file(f, 1, 1, 1);
      finish_file(model_err);

      // header-only file still patches pointers
      f = {8'h34, 8'h12};
      send_file(f, 2, 1, 1);
      finish_file(model_err);

      // short file
      f = {8'h01};
      send_file(f, 2, 1, 1);
      finish_file(model_err);

      // reset during DATA
      f = {8'h00, 8'h20, 8'($urandom), 8'($urandom), 8'($urandom)};
      send_file(f, 1, 1, 0);
      #1 reset_n = 1'b0;
      #1;
      chk_eq("midrst_we",   {31'd0, dma_we}, 0);
      chk_eq("midrst_busy", {31'd0, busy}, 0);
      ioctl_download = 1'b0;
      repeat (3) @(negedge clk);
      chk_eq("midrst_no_ptr", exp_q.size(), 0);
      reset_n = 1'b1;
      repeat (6) @(negedge clk);
      chk_eq("postrst_busy", {31'd0, busy}, 0);
      chk_eq("postrst_done", {31'd0, done}, 0);
      chk_eq("postrst_wait", {31'd0, ioctl_wait}, 0);
      exp_q.delete();
      f = {8'h01, 8'h04, 8'hAA, 8'hBB, 8'hCC};
      send_file(f, 2, 1, 1);
      finish_file(model_err);

      // restart during pointer phase
      f = {8'h00, 8'h08, 8'($urandom), 8'($urandom), 8'($urandom), 8'($urandom)};
      send_file(f, 1, 1, 1);
      t = 0;
      while (exp_q.size() > 3 && t < 100) begin
         @(negedge clk);
         #1;
         t++;
      end
      chk_eq("restart_at_ptr3", exp_q.size(), 3);
      ioctl_download = 1'b1;
      ioctl_wr       = 1'b1;
      ioctl_dout     = 8'h55;
      @(negedge clk);
      ioctl_wr = 1'b0;
      t = 0;
      while (ioctl_wait !== 1'b0 && t < 50) begin
         @(negedge clk);
         t++;
      end
      chk_eq("restart_wait_rel", {31'd0, ioctl_wait}, 0);
      chk_eq("restart_busy", {31'd0, busy}, 1);
      chk_eq("restart_ptr_done", exp_q.size(), 0);
      g = {8'h20, 8'h30, 8'($urandom), 8'($urandom), 8'($urandom)};
      send_file(g, 2, 0, 1);
      finish_file(model_err);

      // randomized files
      for (int k = 0; k < 16; k++) begin
         sel = $urandom_range(0, 3);
         case (sel)
            0:       rla = 16'($urandom_range(0, 'h3FFF));
            1:       rla = 16'('h3FE0 + $urandom_range(0, 'h1F));
            2:       rla = 16'('hFFE0 + $urandom_range(0, 'h1F));
            default: rla = 16'($urandom);
         endcase
         n = $urandom_range(0, 40);
         f.delete();
         f.push_back(rla[7:0]);
         f.push_back(rla[15:8]);
         for (int i = 0; i < n; i++) f.push_back(8'($urandom));
         send_file(f, $urandom_range(1, 3), 1, 1);
         finish_file(model_err);
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/pet2001_prg_loader.md
Name: pet2001_prg_loader

Overview:
- Sits directly upstream of the PET hardware block's DMA RAM port (dma_addr/dma_din/dma_we). Consumes a .PRG byte stream from the host download interface and writes the payload into the 16K main RAM.
- Each .PRG file is a 2-byte little-endian load address followed by payload bytes.
- On download completion, patches the three BASIC end-of-program pointers (VARTAB/ARYTAB/STREND) so a loaded program can RUN directly.

Parameters:
- PTR_BASE, 14'h002A: RAM address of VARTAB low byte. Six consecutive bytes hold VARTAB, ARYTAB, STREND as lo/hi pairs.
- RAM_TOP, 17'h04000: first address beyond writable RAM. Payload at or above this is dropped.
- PTR_EN, 1: 0 disables the pointer-patch phase.

Ports:
- clk  in  1  system clock, same as the PET hardware block
- reset_n  in  1  asynchronous active-low reset
- ioctl_download  in  1  high for the duration of a file transfer
- ioctl_wr  in  1  one-cycle strobe, ioctl_dout valid
- ioctl_dout  in  8  file byte
- ioctl_wait  out  1  host must hold further strobes
- dma_addr  out  14  RAM write address
- dma_din  out  8  RAM write data
- dma_we  out  1  RAM write strobe, one-cycle pulse
- busy  out  1  download or pointer phase in progress
- done  out  1  sticky, last load completed
- err  out  1  sticky, last load truncated or malformed

Behaviour:
- Reset (async assert, sync deassert to internal logic): state=IDLE; dma_we=0, dma_addr=0, dma_din=0, ioctl_wait=0, busy=0, done=0, err=0; load address, byte count and end address cleared. Reset mid-load aborts immediately; dma_we drops asynchronously; no further pointer writes.
- States: IDLE, HDR_LO, HDR_HI, DATA, PTR, FIN.
- IDLE: on ioctl_download rising edge, go to HDR_LO, clear done/err, set busy.
- HDR_LO: an ioctl_wr latches load_addr[7:0] and moves to HDR_HI.
- HDR_HI: an ioctl_wr latches load_addr[15:8] and moves to DATA. cur = load_addr, 17-bit.
- DATA write path: ioctl_wr at cycle N produces dma_we=1 at N+1 with dma_addr=cur[13:0], dma_din=byte. cur increments by 1. Accepts a strobe every cycle; no stall.
- DATA overflow: if cur >= RAM_TOP, no dma_we, err=1, cur still increments. cur is 17-bit so 16'hFFFF+1 does not wrap.
- Download end, any state other than DATA: ioctl_download falling in HDR_LO/HDR_HI (file under 2 bytes) sets err=1, goes to FIN, no pointer writes.
- Download end, DATA: ioctl_download falling computes end = min(cur, RAM_TOP). Goes to PTR if PTR_EN, else FIN.
- Zero-payload file (header only): end = load_addr. Pointers are still written.
- PTR: six consecutive cycles of dma_we=1 at PTR_BASE+0..5. Data alternates end[7:0], end[15:8]. ioctl_wait=1 throughout PTR.
- Download restart during PTR: ioctl_download rising while in PTR is latched. After the final pointer write, go to HDR_LO instead of FIN. Any ioctl_wr during PTR is ignored.
- FIN: done=1, busy=0, then IDLE.
- busy: high from ioctl_download rise through the last PTR write.
- ioctl_wr outside a download: ignored.
- dma_we is never high two cycles for the same byte.
- Loader drives dma_* exclusively while busy. Outside busy, dma_we=0.

Test Plan:
- Basic load: file 01 04 AA BB CC, one strobe per 2 cycles. Expect:
  - writes 0401=AA, 0402=BB, 0403=CC, each one cycle after its strobe;
  - then 002A..002F = 04 04 04 04 04 04;
  - done=1, err=0.
- Back-to-back strobes: 258 bytes with ioctl_wr every cycle, header 00 10. Expect 256 consecutive dma_we cycles at 1000..10FF with matching data, VARTAB=1100.
- Overflow: header FE 3F, 4 payload bytes. Expect:
  - writes only 3FFE and 3FFF;
  - err=1;
  - pointer bytes 00 40 ×3.
- Short file: download of a single byte 01. Expect no dma_we, err=1, done=1.
- Reset mid-DATA: reset_n low after 3 payload writes. Expect:
  - dma_we=0 immediately, busy=0, state IDLE, no pointer writes;
  - a following download behaves as in the basic-load case.
- Restart during PTR: ioctl_download rises at PTR write 3. Expect:
  - all 6 pointer writes complete with ioctl_wait=1;
  - the new file's header is taken from the first strobe afterwards.
